// File: rtl/serdes_pkg.sv
// Constants and helpers shared by the serializer and deserializer models.
package serdes_pkg;
   localparam int DW_MIN = 2;
   localparam int DW_MAX = 8;
   localparam int CNT_W = $clog2(DW_MAX);
   localparam logic [7:0] TRAIN_PATTERN_DEFAULT = 8'h2C;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/oserdes_tx_if.sv
// Parallel-load / serial-out bundle of oserdes_tx; master drives words, slave serializes.
interface oserdes_tx_if #(
   parameter int DATA_WIDTH = 4
);
   logic                  OCE;
   logic [DATA_WIDTH-1:0] D;
   logic                  DVALID;
   logic                  DREADY;
   logic                  OQ;
   logic                  UNDERRUN;
   logic [7:0]            UNDERRUN_CNT;

   modport master (output OCE, D, DVALID, input DREADY, OQ, UNDERRUN, UNDERRUN_CNT);
   modport slave  (input OCE, D, DVALID, output DREADY, OQ, UNDERRUN, UNDERRUN_CNT);
endinterface

// File: rtl/serdes_bitcnt.sv
// Enable-gated bit counter wrapping 0..MAX_VAL; reset value is a parameter so the
// receiver side can start at a different phase.
module serdes_bitcnt #(
   parameter int               CNT_W   = 3,
   parameter logic [CNT_W-1:0] MAX_VAL = '1,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = (cnt_q == MAX_VAL) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= RST_VAL;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/oserdes_tx.sv
// Parallel-to-serial transmitter, LSB first, one word per DATA_WIDTH enabled cycles.
// Define OSERDES_TRAIN_EN to send TRAIN_PATTERN on underrun slots (else all-zero).
module oserdes_tx
   import serdes_pkg::*;
#(
   parameter int         DATA_WIDTH    = 4,
   parameter logic [7:0] TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT
) (
   input logic          CLK0,
   input logic          RST,
   oserdes_tx_if.slave  bus
);
   if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_bad_width
      $error("oserdes_tx: DATA_WIDTH out of range");
   end

`ifdef OSERDES_TRAIN_EN
   localparam bit TRAIN_ON = 1'b1;
`else
   localparam bit TRAIN_ON = 1'b0;
`endif
   localparam logic [DATA_WIDTH-1:0] IDLE_WORD =
      TRAIN_ON ? TRAIN_PATTERN[DATA_WIDTH-1:0] : '0;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic [CNT_W-1:0]      cnt;
   logic                  slot;
   logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
   logic                  oq_q, oq_d;
   logic                  ur_q, ur_d;
   logic [7:0]            ur_cnt_q, ur_cnt_d;

   // Reset parks the counter on the last bit so the first enabled cycle is a load slot.
   serdes_bitcnt #(
      .CNT_W   (CNT_W),
      .MAX_VAL (LAST_BIT),
      .RST_VAL (LAST_BIT)
   ) u_bitcnt (
      .clk_i (CLK0),
      .rst_i (RST),
      .en_i  (bus.OCE),
      .cnt_o (cnt)
   );

   assign slot = bus.OCE & (cnt == LAST_BIT);

   always_comb begin
      sreg_d   = sreg_q;
      oq_d     = oq_q;
      ur_d     = ur_q;
      ur_cnt_d = ur_cnt_q;
      if (bus.OCE) begin
         if (slot) begin
            if (bus.DVALID) begin
               sreg_d = bus.D;
            end else begin
               sreg_d   = IDLE_WORD;
               ur_d     = 1'b1;
               ur_cnt_d = sat_inc(ur_cnt_q);
            end
         end else begin
            sreg_d = sreg_q >> 1;
         end
         // OQ tracks the LSB the register is about to hold, giving one cycle of latency.
         oq_d = sreg_d[0];
      end
   end

   always_ff @(posedge CLK0) begin
      if (RST) begin
         sreg_q   <= '0;
         oq_q     <= 1'b0;
         ur_q     <= 1'b0;
         ur_cnt_q <= 8'd0;
      end else begin
         sreg_q   <= sreg_d;
         oq_q     <= oq_d;
         ur_q     <= ur_d;
         ur_cnt_q <= ur_cnt_d;
      end
   end

   assign bus.DREADY       = slot & ~RST;
   assign bus.OQ           = oq_q;
   assign bus.UNDERRUN     = ur_q;
   assign bus.UNDERRUN_CNT = ur_cnt_q;
endmodule

// File: tb/tb_oserdes_tx.sv
// Directed bench for oserdes_tx: a 4-bit instance for data paths and a 8-bit instance
// for underrun / training-pattern behaviour.
module tb_oserdes_tx;
   logic clk;
   logic rst4, rst8;
   int   total, bad;
   logic [7:0] idle8;

   oserdes_tx_if #(.DATA_WIDTH(4)) bus4 ();
   oserdes_tx_if #(.DATA_WIDTH(8)) bus8 ();

   oserdes_tx #(.DATA_WIDTH(4)) u_dut4 (.CLK0(clk), .RST(rst4), .bus(bus4.slave));
   oserdes_tx #(.DATA_WIDTH(8)) u_dut8 (.CLK0(clk), .RST(rst8), .bus(bus8.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      step();
      total++; if (bus4.OQ !== 1'b0) begin bad++; $display("FAIL reset_oq got=%b exp=0", bus4.OQ); end
      total++; if (bus4.UNDERRUN !== 1'b0) begin bad++; $display("FAIL reset_ur got=%b exp=0", bus4.UNDERRUN); end
      total++; if (bus4.UNDERRUN_CNT !== 8'd0) begin bad++; $display("FAIL reset_urcnt got=%0d exp=0", bus4.UNDERRUN_CNT); end
      total++; if (bus4.DREADY !== 1'b0) begin bad++; $display("FAIL reset_dready_in_rst got=%b exp=0", bus4.DREADY); end
      rst4 = 1'b0;
      #1;
      total++; if (bus4.DREADY !== 1'b1) begin bad++; $display("FAIL reset_first_slot got=%b exp=1", bus4.DREADY); end
   endtask

   task automatic test_pattern();
      logic [3:0] w;
      w = 4'b1011;
      bus4.D = w;
      bus4.DVALID = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         total++; if (bus4.OQ !== w[i%4]) begin bad++; $display("FAIL pattern_oq cyc=%0d got=%b exp=%b", i, bus4.OQ, w[i%4]); end
         total++; if (bus4.DREADY !== (i%4 == 3)) begin bad++; $display("FAIL pattern_dready cyc=%0d got=%b exp=%b", i, bus4.DREADY, (i%4 == 3)); end
      end
      total++; if (bus4.UNDERRUN !== 1'b0) begin bad++; $display("FAIL pattern_ur got=%b exp=0", bus4.UNDERRUN); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] words [4];
      words = '{4'hA, 4'h5, 4'h3, 4'hE};
      for (int j = 0; j < 4; j++) begin
         bus4.D = words[j];
         for (int b = 0; b < 4; b++) begin
            step();
            total++; if (bus4.OQ !== words[j][b]) begin bad++; $display("FAIL b2b_oq word=%0d bit=%0d got=%b exp=%b", j, b, bus4.OQ, words[j][b]); end
         end
      end
      total++; if (bus4.UNDERRUN !== 1'b0) begin bad++; $display("FAIL b2b_ur got=%b exp=0", bus4.UNDERRUN); end
   endtask

   task automatic test_oce_freeze();
      logic [3:0] w, w2;
      w  = 4'b1010;
      w2 = 4'b0011;
      bus4.D = w;
      step();
      total++; if (bus4.OQ !== 1'b0) begin bad++; $display("FAIL freeze_bit0 got=%b exp=0", bus4.OQ); end
      step();
      total++; if (bus4.OQ !== 1'b1) begin bad++; $display("FAIL freeze_bit1 got=%b exp=1", bus4.OQ); end
      bus4.OCE = 1'b0;
      bus4.D = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (bus4.OQ !== 1'b1) begin bad++; $display("FAIL freeze_hold cyc=%0d got=%b exp=1", i, bus4.OQ); end
         total++; if (bus4.DREADY !== 1'b0) begin bad++; $display("FAIL freeze_dready cyc=%0d got=%b exp=0", i, bus4.DREADY); end
      end
      bus4.OCE = 1'b1;
      step();
      total++; if (bus4.OQ !== w[2]) begin bad++; $display("FAIL freeze_bit2 got=%b exp=%b", bus4.OQ, w[2]); end
      step();
      total++; if (bus4.OQ !== w[3]) begin bad++; $display("FAIL freeze_bit3 got=%b exp=%b", bus4.OQ, w[3]); end
      total++; if (bus4.DREADY !== 1'b1) begin bad++; $display("FAIL freeze_realign got=%b exp=1", bus4.DREADY); end
      bus4.D = w2;
      for (int b = 0; b < 4; b++) begin
         step();
         total++; if (bus4.OQ !== w2[b]) begin bad++; $display("FAIL freeze_next bit=%0d got=%b exp=%b", b, bus4.OQ, w2[b]); end
      end
      total++; if (bus4.UNDERRUN_CNT !== 8'd0) begin bad++; $display("FAIL freeze_urcnt got=%0d exp=0", bus4.UNDERRUN_CNT); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] w, w2;
      w  = 4'b1101;
      w2 = 4'b0111;
      bus4.DVALID = 1'b0;
      for (int i = 0; i < 4; i++) step();
      total++; if (bus4.UNDERRUN !== 1'b1) begin bad++; $display("FAIL rstmid_ur_pre got=%b exp=1", bus4.UNDERRUN); end
      total++; if (bus4.UNDERRUN_CNT !== 8'd1) begin bad++; $display("FAIL rstmid_urcnt_pre got=%0d exp=1", bus4.UNDERRUN_CNT); end
      bus4.DVALID = 1'b1;
      bus4.D = w;
      for (int b = 0; b < 3; b++) begin
         step();
         total++; if (bus4.OQ !== w[b]) begin bad++; $display("FAIL rstmid_bit bit=%0d got=%b exp=%b", b, bus4.OQ, w[b]); end
      end
      rst4 = 1'b1;
      step();
      total++; if (bus4.OQ !== 1'b0) begin bad++; $display("FAIL rstmid_oq got=%b exp=0", bus4.OQ); end
      total++; if (bus4.UNDERRUN !== 1'b0) begin bad++; $display("FAIL rstmid_ur got=%b exp=0", bus4.UNDERRUN); end
      total++; if (bus4.UNDERRUN_CNT !== 8'd0) begin bad++; $display("FAIL rstmid_urcnt got=%0d exp=0", bus4.UNDERRUN_CNT); end
      total++; if (bus4.DREADY !== 1'b0) begin bad++; $display("FAIL rstmid_dready_rst got=%b exp=0", bus4.DREADY); end
      rst4 = 1'b0;
      bus4.D = w2;
      #1;
      total++; if (bus4.DREADY !== 1'b1) begin bad++; $display("FAIL rstmid_dready_rel got=%b exp=1", bus4.DREADY); end
      for (int b = 0; b < 4; b++) begin
         step();
         total++; if (bus4.OQ !== w2[b]) begin bad++; $display("FAIL rstmid_new bit=%0d got=%b exp=%b", b, bus4.OQ, w2[b]); end
      end
      rst4 = 1'b1;
   endtask

   task automatic test_underrun8();
      rst8 = 1'b0;
      #1;
      total++; if (bus8.DREADY !== 1'b1) begin bad++; $display("FAIL ur8_first_slot got=%b exp=1", bus8.DREADY); end
      for (int i = 0; i < 24; i++) begin
         step();
         total++; if (bus8.OQ !== idle8[i%8]) begin bad++; $display("FAIL ur8_oq cyc=%0d got=%b exp=%b", i, bus8.OQ, idle8[i%8]); end
      end
      total++; if (bus8.UNDERRUN !== 1'b1) begin bad++; $display("FAIL ur8_flag got=%b exp=1", bus8.UNDERRUN); end
      total++; if (bus8.UNDERRUN_CNT !== 8'd3) begin bad++; $display("FAIL ur8_cnt got=%0d exp=3", bus8.UNDERRUN_CNT); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 251 * 8; i++) step();
      total++; if (bus8.UNDERRUN_CNT !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", bus8.UNDERRUN_CNT); end
      for (int i = 0; i < 8; i++) step();
      total++; if (bus8.UNDERRUN_CNT !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", bus8.UNDERRUN_CNT); end
      for (int i = 0; i < 45 * 8; i++) step();
      total++; if (bus8.UNDERRUN_CNT !== 8'd255) begin bad++; $display("FAIL sat_300 got=%0d exp=255", bus8.UNDERRUN_CNT); end
      total++; if (bus8.UNDERRUN !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", bus8.UNDERRUN); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
`ifdef OSERDES_TRAIN_EN
      idle8 = 8'h2C;
`else
      idle8 = 8'h00;
`endif
      rst4 = 1'b1;
      rst8 = 1'b1;
      bus4.OCE = 1'b1;
      bus4.D = '0;
      bus4.DVALID = 1'b0;
      bus8.OCE = 1'b1;
      bus8.D = '0;
      bus8.DVALID = 1'b0;

      test_reset();
      test_pattern();
      test_back_to_back();
      test_oce_freeze();
      test_reset_mid();
      test_underrun8();
      test_saturate();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/oserdes_tx.md
OSERDES_TX -- requirements
Module: oserdes_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, the serialization ratio (legal 2..8).
REQ-002 SHALL have parameter TRAIN_PATTERN, default 8'h2C, the idle word sent when no data is offered (low DATA_WIDTH bits used).
REQ-003 SHALL have port CLK0  input  1  serial bit clock, the only clock.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port OCE  input  1  clock enable; low freezes all state.
REQ-006 SHALL have port D  input  DATA_WIDTH  parallel word; bit 0 is transmitted first.
REQ-007 SHALL have port DVALID  input  1  D holds a word to send.
REQ-008 SHALL have port DREADY  output  1  word load slot; a word transfers when DVALID and DREADY are both high.
REQ-009 SHALL have port OQ  output  1  registered serial data.
REQ-010 SHALL have port UNDERRUN  output  1  sticky flag: a load slot passed with DVALID low.
REQ-011 SHALL have port UNDERRUN_CNT  output  8  saturating count of underrun slots.

Function
REQ-012 SHALL keep a bit counter cnt that runs 0..DATA_WIDTH-1 and wraps to 0, advancing only when OCE=1.
REQ-013 SHALL drive DREADY = OCE & ~RST & (cnt==DATA_WIDTH-1), combinationally.
REQ-014 SHALL load the shift register from D on a slot cycle with DVALID=1.
REQ-015 SHALL load TRAIN_PATTERN on a slot cycle with DVALID=0 (see REQ-025), set UNDERRUN and increment UNDERRUN_CNT, saturating at 255.
REQ-016 SHALL shift right by one on every other OCE=1 cycle, and register OQ from the shift register LSB.
REQ-017 SHALL put bit 0 of a word accepted in cycle n on OQ in cycle n+1, and bit k in cycle n+1+k; latency is 1 cycle.
REQ-018 SHALL sustain back-to-back words with no gap bits: one word every DATA_WIDTH enabled cycles.
REQ-019 SHALL hold cnt, the shift register, OQ and the counters when OCE=0; DREADY stays low.
REQ-020 SHALL ignore D and DVALID outside slot cycles; no word is consumed.
REQ-021 SHALL clear UNDERRUN only by reset.

Reset
REQ-022 SHALL, on a CLK0 edge with RST=1, set OQ=0, the shift register to 0, UNDERRUN=0 and UNDERRUN_CNT=0.
REQ-023 SHALL set cnt to DATA_WIDTH-1 on reset, so the first enabled cycle after reset release is a slot cycle.
REQ-024 SHALL abort any word in flight when reset is asserted mid-word; the word is not resumed.

Configuration
REQ-025 SHALL compile the training-pattern feature in only when macro OSERDES_TRAIN_EN is defined.
- Defined: underrun slots load TRAIN_PATTERN (REQ-015).
- Undefined: underrun slots load all-zero; UNDERRUN and UNDERRUN_CNT still update.

Structure
REQ-026 SHALL place DATA_WIDTH bounds (min 2, max 8) and the default training pattern constant in a shared package serdes_pkg.
- The ISERDES2 receiver model shares serdes_pkg.
REQ-027 SHALL implement the wrapping enable-gated bit counter as sub-module serdes_bitcnt.
- serdes_bitcnt takes the reset-load value as a parameter and is reused by the receiver side.

Verification
REQ-028 SHALL cover: DATA_WIDTH=4, reset, then D=4'b1011 held valid -> OQ sequence 1,1,0,1 repeating from the cycle after the first slot; UNDERRUN=0.
REQ-029 SHALL cover: DATA_WIDTH=8, OSERDES_TRAIN_EN defined, DVALID=0 for 3 slots -> OQ carries 8'h2C LSB-first three times; UNDERRUN=1; UNDERRUN_CNT=3.
REQ-030 SHALL cover: same stimulus as REQ-029 with OSERDES_TRAIN_EN undefined -> OQ=0 throughout; UNDERRUN_CNT=3.
REQ-031 SHALL cover: OCE pulled low for 5 cycles mid-word -> OQ frozen; resumption yields the remaining bits in order with no lost or duplicated bit.
REQ-032 SHALL cover: RST asserted at bit 2 of a word -> next cycle OQ=0 and counters=0; after release, DREADY=1 on the first cycle and the new word is sent intact.
REQ-033 SHALL cover: 300 underrun slots -> UNDERRUN_CNT saturates at 255.
